// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
// Control FSM for a multicycle RV32I core with one shared instruction/data
// memory. Each instruction runs as fetch, decode, execute/memory and
// writeback. The block drives every datapath mux select and write enable.
//
// Ports:
//   clk, reset (async, active-low)
//   op, funct3, funct7b5 : instruction fields from the instruction register
//   Zero                 : ALU zero flag (qualifies beq)
//   mem_ready            : memory completed the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite : datapath controls
//   illegal              : sticky, set once an unsupported opcode is decoded
//   state                : current FSM state, for debug
//
// Handshake: in FETCH, MEMREAD and MEMWRITE the FSM holds its state and all
// its outputs until it samples mem_ready=1 on a rising clock edge. In every
// other state mem_ready is ignored.
module riscv_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic               RegWrite,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    illegal_q;
    logic    pc_update, branch;
    logic    ir_write_raw, mem_write_raw, reg_write_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_ILLEGAL)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
                if (mem_ready)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target PC_old + imm lands in ALUOut for BEQ.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready)
                    state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready)
                    state_d = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                // rd <= old PC + 4 computed here; PC takes the target from ALUOut.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            ALUOP_SUB: ALUControl = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op[5] separates R-type from I-type so addi never subtracts.
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE: ImmSrc = 2'b01;
            OP_BEQ:   ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // Enables are gated by reset so an in-flight write drops as soon as
    // reset asserts, independent of the clock.
    assign PCWrite  = reset & (pc_update | (branch & Zero));
    assign IRWrite  = reset & ir_write_raw;
    assign MemWrite = reset & mem_write_raw;
    assign RegWrite = reset & reg_write_raw;
    assign illegal  = illegal_q;
    assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: directed reset, a table of
// per-instruction vectors, hand-written multi-cycle sequences, and random
// instruction streams with random mem_ready checked against a path model.
module tb_riscv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    riscv_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level rules.
    function automatic int funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 1 : 0;
            3'b010:  return 5;
            3'b110:  return 3;
            3'b111:  return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 1;
        if (o == 7'b1100011) return 2;
        if (o == 7'b1101111) return 3;
        return 0;
    endfunction

    // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB} per state
    logic [6:0] sel_tab[12];
    int path[$];
    int exp_states[$];
    bit mr_pat[$];
    logic [6:0] ops[6];

    task automatic build_path(input logic [6:0] o);
        path.delete();
        case (o)
            7'b0000011: path = '{0, 1, 2, 3, 4};
            7'b0100011: path = '{0, 1, 2, 5};
            7'b0110011: path = '{0, 1, 6, 7};
            7'b0010011: path = '{0, 1, 8, 7};
            7'b1101111: path = '{0, 1, 9, 7};
            default:    path = '{0, 1, 10};
        endcase
    endtask

    // Runs one instruction with mem_ready=1 from FETCH back to FETCH.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             output int cyc, output int alu3, output int imm);
        op = o; funct3 = f3; funct7b5 = f7; Zero = 1'b0; mem_ready = 1'b1;
        cyc = 0; alu3 = -1; imm = -1;
        do begin
            @(negedge clk);
            if (cyc == 0) imm = int'(ImmSrc);
            if (cyc == 2) alu3 = int'(ALUControl);
            cyc++;
            @(posedge clk); #1;
        end while (state != 4'd0 && cyc < 20);
    endtask

    // Walks exp_states with mem_ready from mr_pat, starting in FETCH.
    task automatic run_seq(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int exp_alu);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        for (int i = 0; i < exp_states.size(); i++) begin
            int s;
            s = exp_states[i];
            mem_ready = mr_pat[i];
            @(negedge clk);
            chk({nm, "_state"}, int'(state), s);
            chk({nm, "_regwrite"}, int'(RegWrite), (s == 4 || s == 7) ? 1 : 0);
            if (s == 6 || s == 8) chk({nm, "_alu"}, int'(ALUControl), exp_alu);
            if (s == 4) chk({nm, "_resultsrc"}, int'(ResultSrc), 1);
            if (s == 10) chk({nm, "_beq_pcwrite"}, int'(PCWrite), int'(z));
            @(posedge clk); #1;
        end
        chk({nm, "_back_to_fetch"}, int'(state), 0);
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        int         cycles;
        int         alu;
        int         imm;
    } vec_t;

    vec_t tab[11];

    initial begin
        int cyc, alu3, imm;

        sel_tab[0]  = {1'b0, 2'b10, 2'b00, 2'b10};
        sel_tab[1]  = {1'b0, 2'b00, 2'b01, 2'b01};
        sel_tab[2]  = {1'b0, 2'b00, 2'b10, 2'b01};
        sel_tab[3]  = {1'b1, 2'b00, 2'b00, 2'b00};
        sel_tab[4]  = {1'b0, 2'b01, 2'b00, 2'b00};
        sel_tab[5]  = {1'b1, 2'b00, 2'b00, 2'b00};
        sel_tab[6]  = {1'b0, 2'b00, 2'b10, 2'b00};
        sel_tab[7]  = {1'b0, 2'b00, 2'b00, 2'b00};
        sel_tab[8]  = {1'b0, 2'b00, 2'b10, 2'b01};
        sel_tab[9]  = {1'b0, 2'b00, 2'b01, 2'b10};
        sel_tab[10] = {1'b0, 2'b00, 2'b10, 2'b00};
        sel_tab[11] = 7'd0;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

        tab[0]  = '{7'b0110011, 3'b000, 1'b0, 4, 0, 0};
        tab[1]  = '{7'b0110011, 3'b000, 1'b1, 4, 1, 0};
        tab[2]  = '{7'b0110011, 3'b010, 1'b0, 4, 5, 0};
        tab[3]  = '{7'b0110011, 3'b111, 1'b1, 4, 2, 0};
        tab[4]  = '{7'b0010011, 3'b000, 1'b1, 4, 0, 0};
        tab[5]  = '{7'b0010011, 3'b110, 1'b0, 4, 3, 0};
        tab[6]  = '{7'b0010011, 3'b001, 1'b0, 4, 0, 0};
        tab[7]  = '{7'b0000011, 3'b010, 1'b0, 5, 0, 0};
        tab[8]  = '{7'b0100011, 3'b010, 1'b0, 4, 0, 1};
        tab[9]  = '{7'b1100011, 3'b000, 1'b0, 3, 1, 2};
        tab[10] = '{7'b1101111, 3'b000, 1'b0, 4, 0, 3};

        // Reset: held low two cycles with mem_ready=1.
        reset = 1'b0; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'd0;
        funct7b5 = 1'b0; Zero = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_state", int'(state), 0);
            chk("rst_pcwrite", int'(PCWrite), 0);
            chk("rst_irwrite", int'(IRWrite), 0);
            chk("rst_regwrite", int'(RegWrite), 0);
            chk("rst_memwrite", int'(MemWrite), 0);
            chk("rst_illegal", int'(illegal), 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_irwrite", int'(IRWrite), 1);
        chk("rel_pcwrite", int'(PCWrite), 1);
        chk("rel_alusrcb", int'(ALUSrcB), 2);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("fetch_wait_state", int'(state), 0);
        chk("fetch_wait_irwrite", int'(IRWrite), 0);
        chk("fetch_wait_pcwrite", int'(PCWrite), 0);
        chk("fetch_wait_alusrcb", int'(ALUSrcB), 2);
        @(posedge clk); #1;

        // Table of single instructions.
        for (int i = 0; i < 11; i++) begin
            run_instr(tab[i].op, tab[i].f3, tab[i].f7, cyc, alu3, imm);
            chk($sformatf("vec%0d_cycles", i), cyc, tab[i].cycles);
            chk($sformatf("vec%0d_alu", i), alu3, tab[i].alu);
            chk($sformatf("vec%0d_imm", i), imm, tab[i].imm);
        end

        // R-type sub.
        exp_states = '{0, 1, 6, 7};
        mr_pat     = '{1, 1, 1, 1};
        run_seq("rsub", 7'b0110011, 3'b000, 1'b1, 1'b0, 1);

        // lw with three wait cycles in MEMREAD.
        exp_states = '{0, 1, 2, 3, 3, 3, 3, 4};
        mr_pat     = '{1, 1, 1, 0, 0, 0, 1, 1};
        run_seq("lw_wait", 7'b0000011, 3'b010, 1'b0, 1'b0, 0);

        // beq taken and not taken.
        exp_states = '{0, 1, 10};
        mr_pat     = '{1, 1, 1};
        run_seq("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 0);
        run_seq("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 0);

        // I-type add with funct7b5=1 and ori.
        exp_states = '{0, 1, 8, 7};
        mr_pat     = '{1, 1, 1, 1};
        run_seq("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 0);
        run_seq("ori", 7'b0010011, 3'b110, 1'b0, 1'b0, 3);

        // Random instruction stream with random mem_ready.
        for (int n = 0; n < 80; n++) begin
            int idx;
            op       = ops[$urandom_range(0, 5)];
            funct3   = 3'($urandom_range(0, 7));
            funct7b5 = 1'($urandom_range(0, 1));
            Zero     = 1'($urandom_range(0, 1));
            build_path(op);
            idx = 0;
            while (idx < path.size()) begin
                int s, ea;
                logic mr;
                s  = path[idx];
                mr = 1'($urandom_range(0, 1));
                mem_ready = mr;
                @(negedge clk);
                ea = (s == 6 || s == 8) ? funct_alu(op, funct3, funct7b5) : (s == 10) ? 1 : 0;
                chk("rnd_state", int'(state), s);
                chk("rnd_regwrite", int'(RegWrite), (s == 4 || s == 7) ? 1 : 0);
                chk("rnd_memwrite", int'(MemWrite), (s == 5) ? 1 : 0);
                chk("rnd_irwrite", int'(IRWrite), (s == 0 && mr) ? 1 : 0);
                chk("rnd_pcwrite", int'(PCWrite),
                    ((s == 0 && mr) || s == 9 || (s == 10 && Zero)) ? 1 : 0);
                chk("rnd_alu", int'(ALUControl), ea);
                chk("rnd_imm", int'(ImmSrc), imm_of(op));
                chk("rnd_sel", int'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}), int'(sel_tab[s]));
                chk("rnd_illegal", int'(illegal), 0);
                if (!((s == 0 || s == 3 || s == 5) && !mr)) idx++;
                @(posedge clk); #1;
            end
        end
        chk("rnd_end_fetch", int'(state), 0);

        // Reset during a stalled store drops MemWrite at once.
        op = 7'b0100011; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sw_stall_state", int'(state), 5);
        chk("sw_stall_memwrite", int'(MemWrite), 1);
        #2 reset = 1'b0;
        #1;
        chk("sw_rst_memwrite", int'(MemWrite), 0);
        chk("sw_rst_state", int'(state), 0);
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = 1'b1;

        // Unsupported opcode locks up until reset.
        op = 7'b1111111;
        repeat (2) @(posedge clk);
        #1;
        repeat (10) begin
            @(negedge clk);
            chk("ill_state", int'(state), 11);
            chk("ill_flag", int'(illegal), 1);
            chk("ill_pcwrite", int'(PCWrite), 0);
            chk("ill_irwrite", int'(IRWrite), 0);
            chk("ill_regwrite", int'(RegWrite), 0);
            chk("ill_memwrite", int'(MemWrite), 0);
        end
        #2 reset = 1'b0;
        #1;
        chk("ill_rst_state", int'(state), 0);
        chk("ill_rst_flag", int'(illegal), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_ill_state", int'(state), 0);
        chk("post_ill_flag", int'(illegal), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
